ff_mul_k4_q2: RTL and testbench

//  Multiplies two elements of GF(2^4) (K=4 bits over GF(2), Q=2).

---
 rtl/ff_mul_k4_q2.sv | 105 ++++++++++
 tb/tb_ff_mul_k4_q2.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ff_mul_k4_q2.sv
// GF(2^4) multiplier with a registered output and a valid strobe. Latency is 1 cycle.
// Field reduction polynomial: x^4 + POLY_LOW (default x^4 + x + 1).
// Optional feature: define FFMUL_INV_EN to add inv_out, a registered inverse of in1.
module ff_mul_k4_q2 #(
    parameter logic [3:0] POLY_LOW = 4'h3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    output logic       out_valid,
    output logic [3:0] mul_out
`ifdef FFMUL_INV_EN
    ,
    output logic [3:0] inv_out
`endif
);

    logic [6:0] prod_raw;
    logic [6:0] prod_red;
    logic [3:0] prod;

    logic       out_valid_q;
    logic [3:0] mul_q;
    logic [3:0] mul_d;

    // Carry-less product, then fold the top bits back in from bit 6 down to bit 4
    always_comb begin
        prod_raw = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                prod_raw[i+j] = prod_raw[i+j] ^ (in1[i] & in2[j]);
            end
        end
        prod_red = prod_raw;
        for (int k = 6; k >= 4; k--) begin
            if (prod_red[k]) begin
                prod_red    = prod_red ^ ({3'b000, POLY_LOW} << (k - 4));
                prod_red[k] = 1'b0;
            end
        end
        prod = prod_red[3:0];
    end

    // Capture a new product only when operands are valid; otherwise hold
    always_comb begin
        mul_d = in_valid ? prod : mul_q;
    end

    // Output registers; reset discards any result in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            mul_q       <= 4'h0;
        end else begin
            out_valid_q <= in_valid;
            mul_q       <= mul_d;
        end
    end

    assign out_valid = out_valid_q;
    assign mul_out   = mul_q;

`ifdef FFMUL_INV_EN
    logic [3:0] inv_lut;
    logic [3:0] inv_q;
    logic [3:0] inv_d;

    // Inverse table for x^4 + x + 1; inv(0) is defined as 0
    always_comb begin
        unique case (in1)
            4'h0:    inv_lut = 4'h0;
            4'h1:    inv_lut = 4'h1;
            4'h2:    inv_lut = 4'h9;
            4'h3:    inv_lut = 4'he;
            4'h4:    inv_lut = 4'hd;
            4'h5:    inv_lut = 4'hb;
            4'h6:    inv_lut = 4'h7;
            4'h7:    inv_lut = 4'h6;
            4'h8:    inv_lut = 4'hf;
            4'h9:    inv_lut = 4'h2;
            4'ha:    inv_lut = 4'hc;
            4'hb:    inv_lut = 4'h5;
            4'hc:    inv_lut = 4'ha;
            4'hd:    inv_lut = 4'h4;
            4'he:    inv_lut = 4'h3;
            default: inv_lut = 4'h8;
        endcase
        inv_d = in_valid ? inv_lut : inv_q;
    end

    // Inverse register shares timing and valid with the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 4'h0;
        end else begin
            inv_q <= inv_d;
        end
    end

    assign inv_out = inv_q;
`endif

endmodule

// File: tb/tb_ff_mul_k4_q2.sv
// Directed self-checking bench for ff_mul_k4_q2 (optionally with FFMUL_INV_EN).
module tb_ff_mul_k4_q2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       out_valid;
    logic [3:0] mul_out;
`ifdef FFMUL_INV_EN
    logic [3:0] inv_out;
`endif

    int checks;
    int failures;
    logic [3:0] res [256];

    ff_mul_k4_q2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .mul_out   (mul_out)
`ifdef FFMUL_INV_EN
        ,
        .inv_out   (inv_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-and-add reference multiplier over x^4 + x + 1
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x;
        logic [3:0] r;
        x = a;
        r = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one operand pair and sample one cycle later
    task automatic step(input logic [3:0] a, input logic [3:0] b);
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in1      = 4'h0;
        in2      = 4'h0;

        // Reset state
        #1;
        check("reset_valid", {3'b000, out_valid}, 4'h0);
        check("reset_mul", mul_out, 4'h0);
`ifdef FFMUL_INV_EN
        check("reset_inv", inv_out, 4'h0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_valid", {3'b000, out_valid}, 4'h0);

        // 5 * 8 = 14
        step(4'h5, 4'h8);
        check("t1_valid", {3'b000, out_valid}, 4'h1);
        check("t1_mul", mul_out, 4'he);

        // Three idle cycles: valid drops, product holds
        in_valid = 1'b0;
        in1      = 4'h3;
        in2      = 4'h7;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {3'b000, out_valid}, 4'h0);
            check("hold_mul", mul_out, 4'he);
        end

        // Further directed vectors
        step(4'hf, 4'hf);
        check("t2_ff", mul_out, 4'ha);
        step(4'h2, 4'h9);
        check("t2_29", mul_out, 4'h1);

        // Exhaustive back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(4'(a), 4'(b));
                check("exh_valid", {3'b000, out_valid}, 4'h1);
                check("exh_mul", mul_out, ref_mul(4'(a), 4'(b)));
                res[a*16+b] = mul_out;
            end
        end
        for (int a = 0; a < 16; a++) begin
            check("zero_left", res[a], 4'h0);
            check("zero_right", res[a*16], 4'h0);
            check("one_left", res[16+a], 4'(a));
            for (int b = a + 1; b < 16; b++) begin
                check("commute", res[a*16+b], res[b*16+a]);
            end
        end

        // Asynchronous reset mid-cycle with operands valid
        step(4'h5, 4'h8);
        check("pre_rst_valid", {3'b000, out_valid}, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {3'b000, out_valid}, 4'h0);
        check("async_mul", mul_out, 4'h0);
        @(posedge clk);
        #1;
        check("rst_hold_mul", mul_out, 4'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", {3'b000, out_valid}, 4'h0);
        check("post_rst_mul", mul_out, 4'h0);
        step(4'h2, 4'h9);
        check("post_rst_new", mul_out, 4'h1);

`ifdef FFMUL_INV_EN
        step(4'h2, 4'h1);
        check("inv_2", inv_out, 4'h9);
        step(4'h0, 4'h1);
        check("inv_0", inv_out, 4'h0);
        for (int a = 1; a < 16; a++) begin
            step(4'(a), 4'h0);
            check("inv_prop", ref_mul(4'(a), inv_out), 4'h1);
        end
`endif

        in_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
